// File: rtl/cla8_seq_ctrl.sv
// Byte-serial wide add/subtract controller. Operands pass LSB byte first through
// one shared 8-bit carry-lookahead adder, with the carry chained through a register.

module cla8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       ci_i,
  output logic [7:0] s_o,
  output logic       co_o
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       acc;
  logic       pp;

  // Each carry is expanded fully from generate/propagate terms and ci,
  // so no carry depends on a lower computed carry.
  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    c[0] = ci_i;
    acc  = 1'b0;
    pp   = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int unsigned k = 0; k < i; k++) begin
        acc = acc | (pp & g[i-1-k]);
        pp  = pp & p[i-1-k];
      end
      c[i+1] = acc | (pp & ci_i);
    end
  end

  assign s_o  = p ^ c[7:0];
  assign co_o = c[8];

endmodule

module cla8_seq_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  co,
  output logic                  ovf
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IDXW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            co_q, co_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [7:0]      add_s;
  logic            add_co;
  logic            last;

  cla8 u_cla8 (
    .a_i  (a_byte),
    .b_i  (b_byte),
    .ci_i (carry_q),
    .s_o  (add_s),
    .co_o (add_co)
  );

  assign last = (idx_q == IDXW'(NBYTES - 1));

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (idx_q == IDXW'(k)) begin
        a_byte = a_q[8*k +: 8];
        b_byte = b_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          a_d      = a;
          // Subtraction is a + ~b + 1: invert B once here, seed carry with 1.
          b_d      = op_sub ? ~b : b;
          carry_d  = op_sub;
          idx_d    = '0;
          result_d = '0;
          co_d     = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      S_RUN: begin
        for (int unsigned k = 0; k < NBYTES; k++) begin
          if (idx_q == IDXW'(k)) begin
            result_d[8*k +: 8] = add_s;
          end
        end
        carry_d = add_co;
        if (last) begin
          state_d = S_DONE;
          idx_d   = '0;
          co_d    = add_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (add_s[7] != a_q[W-1]);
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign co     = co_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_cla8_seq_ctrl.sv
// Self-checking bench for cla8_seq_ctrl: a timeline/arithmetic model checked every
// cycle, plus directed operations with hand-computed results.

module tb_cla8_seq_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         co;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  cla8_seq_ctrl #(.NBYTES(NB)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .co     (co),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic for the values, a cycles-since-accept count
  // for the timing (busy for NB+1 cycles after accept, done on the last of them).
  int           phase = 0;
  bit           m_valid = 0;
  logic [W-1:0] m_res = '0;
  logic         m_co = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_res;
  logic         p_co;
  logic         p_ovf;

  task automatic ref_calc(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                          output logic [W-1:0] r, output logic c, output logic v);
    longint sx, sy, sr;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    if (sub) begin
      sr = sx - sy;
      r  = x - y;
      c  = (ux >= uy);
    end else begin
      sr = sx + sy;
      r  = x + y;
      c  = ((ux + uy) >> W) != 0;
    end
    v = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1;
      phase   = 0;
      m_res   = '0;
      m_co    = 1'b0;
      m_ovf   = 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        ref_calc(a, b, op_sub, p_res, p_co, p_ovf);
        phase = 1;
        m_res = '0;
        m_co  = 1'b0;
        m_ovf = 1'b0;
      end
    end else begin
      phase++;
      if (phase == NB + 1) begin
        m_res = p_res;
        m_co  = p_co;
        m_ovf = p_ovf;
      end else if (phase == NB + 2) begin
        phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 64'(busy), 64'(phase != 0));
      chk("done", 64'(done), 64'(phase == NB + 1));
      if (done) n_done++;
      if (phase == 0 || phase == NB + 1) begin
        chk("result", 64'(result), 64'(m_res));
        chk("co", 64'(co), 64'(m_co));
        chk("ovf", 64'(ovf), 64'(m_ovf));
      end
    end
  end

  task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sub, input logic [W-1:0] er, input logic ec, input logic ev);
    int cyc;
    @(negedge clk);
    a = x; b = y; op_sub = sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op_sub = $urandom_range(0, 1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_latency"}, 64'(cyc), 64'(NB + 1));
    chk({name, "_result"}, 64'(result), 64'(er));
    chk({name, "_co"}, 64'(co), 64'(ec));
    chk({name, "_ovf"}, 64'(ovf), 64'(ev));
    @(negedge clk);
    chk({name, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int d0;
    logic [W-1:0] sp [6];
    sp = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h1, 32'h000000FF};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_co_ovf", 64'({co, ovf}), 64'(0));

    directed("add_ff_1", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
    directed("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    directed("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    directed("sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    directed("sub_ovf", 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    directed("sub_zero", 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0);

    // start held high with changing operands: one op per NB+2 cycles
    d0 = n_done;
    @(negedge clk);
    start = 1'b1;
    for (int unsigned i = 0; i < 3 * (NB + 2); i++) begin
      a = $urandom; b = $urandom; op_sub = $urandom_range(0, 1);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (NB + 3) @(negedge clk);
    chk("held_start_dones", 64'(n_done - d0), 64'(3));

    // reset in the second RUN cycle aborts without a done
    d0 = n_done;
    a = 32'h11111111; b = 32'h22222222; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    repeat (NB + 2) @(negedge clk);
    chk("abort_no_done", 64'(n_done - d0), 64'(0));
    directed("after_abort", 32'h0000FFFF, 32'h00000001, 1'b1, 32'h0000FFFE, 1'b1, 1'b0);

    // randomized operations with random gaps and boundary operands
    for (int unsigned i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : W'($urandom);
      op_sub = $urandom_range(0, 1);
      start = 1'b1;
      @(negedge clk);
      start = $urandom_range(0, 1);
      repeat ($urandom_range(NB, NB + 4)) begin
        a = $urandom; b = $urandom;
        @(negedge clk);
      end
      start = 1'b0;
      while (busy) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
